// File: rtl/tag_lookup_pipe_if.sv
// Lookup, response, fill and invalidate signals of the tag lookup pipeline.
// The master drives requests and fills; the slave (tag store) returns results.
interface tag_lookup_pipe_if #(
  parameter int unsigned N_WAYS   = 2,
  parameter int unsigned N_SETS   = 16,
  parameter int unsigned TAG_BITS = 21
);
  localparam int unsigned WAY_BITS = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam int unsigned SET_BITS = $clog2(N_SETS);

  logic                lk_valid;
  logic                lk_ready;
  logic [SET_BITS-1:0] lk_set;
  logic [TAG_BITS-1:0] lk_tag;
  logic                rsp_valid;
  logic                rsp_hit;
  logic [WAY_BITS-1:0] rsp_way;
  logic [WAY_BITS-1:0] rsp_victim;
  logic                rsp_multihit;
  logic                fill_valid;
  logic [SET_BITS-1:0] fill_set;
  logic [WAY_BITS-1:0] fill_way;
  logic [TAG_BITS-1:0] fill_tag;
  logic                inv_all;
  logic                inv_done;

  modport master (
    output lk_valid, lk_set, lk_tag, fill_valid, fill_set, fill_way, fill_tag, inv_all,
    input  lk_ready, rsp_valid, rsp_hit, rsp_way, rsp_victim, rsp_multihit, inv_done
  );

  modport slave (
    input  lk_valid, lk_set, lk_tag, fill_valid, fill_set, fill_way, fill_tag, inv_all,
    output lk_ready, rsp_valid, rsp_hit, rsp_way, rsp_victim, rsp_multihit, inv_done
  );
endinterface

// File: rtl/tag_lookup_pipe.sv
// Set-associative tag store with registered hit/miss lookup, round-robin victim and swept invalidate-all.
// Optional: define TAG_MULTIHIT_EN to report more than one matching valid way on rsp_multihit.
module tag_lookup_pipe #(
  parameter int unsigned N_WAYS   = 2,
  parameter int unsigned N_SETS   = 16,
  parameter int unsigned TAG_BITS = 21
) (
  input logic               clk,
  input logic               rst,
  tag_lookup_pipe_if.slave  bus
);
  localparam int unsigned WAY_BITS = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam int unsigned SET_BITS = $clog2(N_SETS);
  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(N_SETS - 1);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [SET_BITS-1:0] flush_idx_q, flush_idx_d;
  logic [TAG_BITS-1:0] tag_q [N_SETS][N_WAYS];
  logic [TAG_BITS-1:0] tag_d [N_SETS][N_WAYS];
  logic [N_WAYS-1:0]   valid_q [N_SETS];
  logic [N_WAYS-1:0]   valid_d [N_SETS];
  logic [WAY_BITS-1:0] rr_q [N_SETS];
  logic [WAY_BITS-1:0] rr_d [N_SETS];

  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [WAY_BITS-1:0] rsp_way_q, rsp_way_d;
  logic [WAY_BITS-1:0] rsp_victim_q, rsp_victim_d;
  logic                rsp_multihit_q, rsp_multihit_d;

  logic                accept;
  logic [N_WAYS-1:0]   hit_vec;
  logic [WAY_BITS-1:0] hit_way;
  logic [WAY_BITS-1:0] victim_way;
  logic                multihit;
  logic [WAY_BITS-1:0] rr_next;

  assign bus.lk_ready     = (state_q == IDLE);
  assign accept           = bus.lk_valid && bus.lk_ready;
  assign bus.inv_done     = (state_q == FLUSH) && (flush_idx_q == LAST_SET) && !rst;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_hit      = rsp_hit_q;
  assign bus.rsp_way      = rsp_way_q;
  assign bus.rsp_victim   = rsp_victim_q;
  assign bus.rsp_multihit = rsp_multihit_q;

  assign rr_next = (N_WAYS == 1) ? '0 : WAY_BITS'(bus.fill_way + WAY_BITS'(1));

  // Lookup reads pre-fill state only: a same-cycle fill becomes visible next cycle.
  always_comb begin
    hit_vec    = '0;
    hit_way    = '0;
    victim_way = rr_q[bus.lk_set];
    for (int unsigned i = 0; i < N_WAYS; i++) begin
      hit_vec[i] = valid_q[bus.lk_set][i] && (tag_q[bus.lk_set][i] == bus.lk_tag);
    end
    for (int unsigned i = N_WAYS; i > 0; i--) begin
      if (hit_vec[i-1])                 hit_way    = WAY_BITS'(i - 1);
      if (!valid_q[bus.lk_set][i-1])    victim_way = WAY_BITS'(i - 1);
    end
  end

`ifdef TAG_MULTIHIT_EN
  int unsigned hit_cnt;
  always_comb begin
    hit_cnt = 0;
    for (int unsigned i = 0; i < N_WAYS; i++) begin
      hit_cnt = hit_cnt + {31'd0, hit_vec[i]};
    end
    multihit = (hit_cnt >= 2);
  end
`else
  assign multihit = 1'b0;
`endif

  always_comb begin
    rsp_valid_d    = accept;
    rsp_hit_d      = rsp_hit_q;
    rsp_way_d      = rsp_way_q;
    rsp_victim_d   = rsp_victim_q;
    rsp_multihit_d = rsp_multihit_q;
    if (accept) begin
      rsp_hit_d      = |hit_vec;
      rsp_way_d      = hit_way;
      rsp_victim_d   = victim_way;
      rsp_multihit_d = multihit;
    end
  end

  // Sweep is applied after the fill so a fill to the set being swept this cycle is dropped.
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    rr_d        = rr_q;
    if (bus.fill_valid) begin
      tag_d[bus.fill_set][bus.fill_way]   = bus.fill_tag;
      valid_d[bus.fill_set][bus.fill_way] = 1'b1;
      rr_d[bus.fill_set]                  = rr_next;
    end
    case (state_q)
      IDLE: begin
        if (bus.inv_all) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end
      end
      FLUSH: begin
        valid_d[flush_idx_q] = '0;
        rr_d[flush_idx_q]    = '0;
        flush_idx_d          = flush_idx_q + SET_BITS'(1);
        if (flush_idx_q == LAST_SET) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      flush_idx_q    <= '0;
      valid_q        <= '{default: '0};
      rr_q           <= '{default: '0};
      rsp_valid_q    <= 1'b0;
      rsp_hit_q      <= 1'b0;
      rsp_way_q      <= '0;
      rsp_victim_q   <= '0;
      rsp_multihit_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_idx_q    <= flush_idx_d;
      valid_q        <= valid_d;
      rr_q           <= rr_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_hit_q      <= rsp_hit_d;
      rsp_way_q      <= rsp_way_d;
      rsp_victim_q   <= rsp_victim_d;
      rsp_multihit_q <= rsp_multihit_d;
    end
  end
endmodule

// File: tb/tb_tag_lookup_pipe.sv
// Directed bench for tag_lookup_pipe (N_WAYS=2, N_SETS=16, TAG_BITS=21).
module tb_tag_lookup_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

`ifdef TAG_MULTIHIT_EN
  localparam logic EXP_MULTI = 1'b1;
`else
  localparam logic EXP_MULTI = 1'b0;
`endif

  always #5 clk = ~clk;

  tag_lookup_pipe_if #(.N_WAYS(2), .N_SETS(16), .TAG_BITS(21)) bus ();

  tag_lookup_pipe #(.N_WAYS(2), .N_SETS(16), .TAG_BITS(21)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [3:0] set, input logic way, input logic [20:0] tag);
    bus.fill_valid = 1'b1;
    bus.fill_set   = set;
    bus.fill_way   = way;
    bus.fill_tag   = tag;
    tick();
    bus.fill_valid = 1'b0;
  endtask

  task automatic lookup(input logic [3:0] set, input logic [20:0] tag);
    bus.lk_valid = 1'b1;
    bus.lk_set   = set;
    bus.lk_tag   = tag;
    tick();
    bus.lk_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt;
    int unsigned done_at;
    int unsigned done_seen;

    bus.lk_valid = 1'b0; bus.lk_set = '0; bus.lk_tag = '0;
    bus.fill_valid = 1'b0; bus.fill_set = '0; bus.fill_way = '0; bus.fill_tag = '0;
    bus.inv_all = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_hit", bus.rsp_hit, 0);
    check("rst_rsp_way", bus.rsp_way, 0);
    check("rst_rsp_victim", bus.rsp_victim, 0);
    check("rst_multihit", bus.rsp_multihit, 0);
    check("rst_inv_done", bus.inv_done, 0);
    check("rst_lk_ready", bus.lk_ready, 1);

    lookup(4'd3, 21'h1A);
    check("cold_valid", bus.rsp_valid, 1);
    check("cold_hit", bus.rsp_hit, 0);
    check("cold_victim", bus.rsp_victim, 0);
    tick();
    check("rsp_pulse", bus.rsp_valid, 0);
    check("rsp_hold_hit", bus.rsp_hit, 0);

    fill(4'd3, 1'b1, 21'h1A);
    lookup(4'd3, 21'h1A);
    check("s3_hit", bus.rsp_hit, 1);
    check("s3_way", bus.rsp_way, 1);
    check("s3_victim", bus.rsp_victim, 0);

    fill(4'd5, 1'b0, 21'h100);
    fill(4'd5, 1'b1, 21'h200);
    lookup(4'd5, 21'h333);
    check("s5_miss", bus.rsp_hit, 0);
    check("s5_victim_wrap", bus.rsp_victim, 0);
    lookup(4'd5, 21'h200);
    check("s5_hit", bus.rsp_hit, 1);
    check("s5_way", bus.rsp_way, 1);

    fill(4'd7, 1'b1, 21'h11);
    fill(4'd7, 1'b0, 21'h22);
    lookup(4'd7, 21'h44);
    check("s7_victim_rr", bus.rsp_victim, 1);

    bus.fill_valid = 1'b1; bus.fill_set = 4'd2; bus.fill_way = 1'b0; bus.fill_tag = 21'h7;
    lookup(4'd2, 21'h7);
    bus.fill_valid = 1'b0;
    check("nobypass_hit", bus.rsp_hit, 0);
    lookup(4'd2, 21'h7);
    check("after_fill_hit", bus.rsp_hit, 1);
    check("after_fill_way", bus.rsp_way, 0);

    fill(4'd0, 1'b0, 21'h9);
    fill(4'd0, 1'b1, 21'h9);
    lookup(4'd0, 21'h9);
    check("dup_hit", bus.rsp_hit, 1);
    check("dup_way", bus.rsp_way, 0);
    check("dup_multihit", bus.rsp_multihit, EXP_MULTI);

    // lookup accepted with inv_all sees pre-flush contents
    bus.inv_all = 1'b1;
    lookup(4'd3, 21'h1A);
    bus.inv_all = 1'b0;
    check("flush_start_hit", bus.rsp_hit, 1);
    cnt = 0; done_at = 0;
    while (bus.lk_ready == 1'b0 && cnt < 40) begin
      cnt++;
      if (bus.inv_done) done_at = cnt;
      bus.inv_all    = (cnt == 5);
      bus.fill_valid = (cnt == 4) || (cnt == 6);
      bus.fill_set   = (cnt == 4) ? 4'd1 : 4'd9;
      bus.fill_way   = 1'b0;
      bus.fill_tag   = 21'h55;
      tick();
      bus.inv_all    = 1'b0;
      bus.fill_valid = 1'b0;
    end
    check("flush_len", cnt, 16);
    check("inv_done_cycle", done_at, 16);
    check("post_flush_inv_done", bus.inv_done, 0);
    lookup(4'd3, 21'h1A);
    check("flushed_s3_miss", bus.rsp_hit, 0);
    lookup(4'd5, 21'h200);
    check("flushed_s5_miss", bus.rsp_hit, 0);
    lookup(4'd1, 21'h55);
    check("swept_fill_kept", bus.rsp_hit, 1);
    lookup(4'd9, 21'h55);
    check("unswept_fill_lost", bus.rsp_hit, 0);
    fill(4'd8, 1'b1, 21'h66);
    lookup(4'd8, 21'h66);
    check("post_flush_fill_hit", bus.rsp_hit, 1);

    bus.inv_all = 1'b1;
    tick();
    bus.inv_all = 1'b0;
    check("flush2_ready_low", bus.lk_ready, 0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", bus.lk_ready, 1);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.inv_done) done_seen++;
      tick();
    end
    check("midrst_no_done", done_seen, 0);
    lookup(4'd1, 21'h55);
    check("midrst_s1_cleared", bus.rsp_hit, 0);
    lookup(4'd8, 21'h66);
    check("midrst_s8_cleared", bus.rsp_hit, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
